// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: active-low glyphs
// (bit 0 = segment a .. bit 6 = segment g) and the per-slot state encoding.
package disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Eight-digit multiplexed display scanner with per-slot blanking, frame-wide
// input snapshot, leading-zero suppression and an optional decimal point.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIV    = 50000,
    parameter int DEAD   = 500,
    parameter int DP_POS = 8
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [3:0] bt0,
    input  logic [3:0] bt1,
    input  logic [3:0] bt2,
    input  logic [3:0] bt3,
    input  logic [3:0] bt4,
    input  logic [3:0] bt5,
    input  logic [3:0] bt6,
    input  logic [3:0] bt7,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    // Digits at or below the decimal point are never zero-suppressed; 0 when no DP.
    localparam int DP_PROT = (DP_POS > 7) ? 0 : DP_POS;

    generate
        if (DIV < 2 || DIV > (1 << 20) || DEAD < 1 || DEAD >= DIV) begin : g_bad_params
            $error("disp_scan: illegal DIV/DEAD parameter combination");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [31:0]   bt_all;
    logic          snap_take;

    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic [3:0]    cur_digit;
    logic [6:0]    glyph;
    logic [7:0]    lz_blank;
    logic          zero_run;

    assign bt_all    = {bt7, bt6, bt5, bt4, bt3, bt2, bt1, bt0};
    assign snap_take = (cnt_q == '0) && (idx_q == 3'd0);
    assign cur_digit = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (glyph)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // State tracks the next counter value so BLANK/DRIVE stays aligned with cnt_q.
    always_comb begin
        cnt_d   = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
        idx_d   = (cnt_q == CW'(DIV - 1)) ? idx_q + 3'd1 : idx_q;
        state_d = (cnt_d < CW'(DEAD)) ? ST_BLANK : ST_DRIVE;
        snap_d  = snap_take ? bt_all : snap_q;
    end

    // A digit is suppressed when it and every more significant digit are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = 7; i >= 1; i--) begin
            zero_run    = zero_run & (snap_q[i*4 +: 4] == 4'd0);
            lz_blank[i] = zero_run & (i > DP_PROT);
        end
    end

    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        frame_d = snap_take;
        if (state_q == ST_DRIVE) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = lz_blank[idx_q] ? SEG_BLANK : glyph;
            dp_d  = ~(int'(idx_q) == DP_POS);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV=4, DEAD=1; a second instance uses DP_POS=2.
module tb_disp_scan;

    localparam int DIV  = 4;
    localparam int DEAD = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bt0, bt1, bt2, bt3, bt4, bt5, bt6, bt7;
    logic [7:0] an, an2;
    logic [6:0] seg, seg2;
    logic       dp, dp2, frame, frame2;

    int n_cmp = 0;
    int n_err = 0;

    // Frame capture: index k is cycles since the frame pulse; digit d is driven at k=4d+1..4d+3.
    logic [7:0] c_an  [32];
    logic [6:0] c_seg [32];
    logic       c_dp  [32];
    logic [6:0] c2_seg[32];
    logic       c2_dp [32];

    always #5 clk = ~clk;

    disp_scan #(.DIV(DIV), .DEAD(DEAD), .DP_POS(8)) u_dut (
        .sclk(clk), .rst(rst),
        .bt0(bt0), .bt1(bt1), .bt2(bt2), .bt3(bt3),
        .bt4(bt4), .bt5(bt5), .bt6(bt6), .bt7(bt7),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    disp_scan #(.DIV(DIV), .DEAD(DEAD), .DP_POS(2)) u_dut_dp (
        .sclk(clk), .rst(rst),
        .bt0(bt0), .bt1(bt1), .bt2(bt2), .bt3(bt3),
        .bt4(bt4), .bt5(bt5), .bt6(bt6), .bt7(bt7),
        .an(an2), .seg(seg2), .dp(dp2), .frame(frame2)
    );

    task automatic set_bt(input logic [31:0] v);
        {bt7, bt6, bt5, bt4, bt3, bt2, bt1, bt0} = v;
    endtask

    task automatic wait_frame(output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL wait_frame: frame=%b after 100 cycles, required 1", frame);
        end
    endtask

    task automatic capture_frame;
        bit ok;
        wait_frame(ok);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            c_an[k]   = an;
            c_seg[k]  = seg;
            c_dp[k]   = dp;
            c2_seg[k] = seg2;
            c2_dp[k]  = dp2;
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        set_bt(32'h0000_0009);
        repeat (3) @(negedge clk);
        n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an: got %h required ff", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h required 7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b required 1", dp); end
        n_cmp++; if (frame !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b required 0", frame); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (frame !== 1'b1) begin n_err++; $display("FAIL first_frame: got %b required 1", frame); end
        n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL first_dark: got %h required ff", an); end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin n = i; break; end
        end
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL frame_period: got %0d required 32", n); end
    endtask

    task automatic test_digits;
        set_bt(32'h0001_2345);
        capture_frame();
        n_cmp++; if (c_seg[2] !== 7'h12) begin n_err++; $display("FAIL digit0_five: got %h required 12", c_seg[2]); end
        n_cmp++; if (c_seg[6] !== 7'h19) begin n_err++; $display("FAIL digit1_four: got %h required 19", c_seg[6]); end
        n_cmp++; if (c_seg[14] !== 7'h24) begin n_err++; $display("FAIL digit3_two: got %h required 24", c_seg[14]); end
        n_cmp++; if (c_seg[18] !== 7'h79) begin n_err++; $display("FAIL digit4_one: got %h required 79", c_seg[18]); end
        for (int d = 5; d <= 7; d++) begin
            n_cmp++;
            if (c_seg[4*d+2] !== 7'h7F) begin n_err++; $display("FAIL lz_digit%0d: got %h required 7f", d, c_seg[4*d+2]); end
        end
        n_cmp++; if (c_an[30] !== 8'h7F) begin n_err++; $display("FAIL lz_an_kept: got %h required 7f", c_an[30]); end
        n_cmp++; if (c_an[8] !== 8'hFF) begin n_err++; $display("FAIL slot_dark: got %h required ff", c_an[8]); end
        for (int k = 9; k <= 11; k++) begin
            n_cmp++;
            if (c_an[k] !== 8'hFB) begin n_err++; $display("FAIL slot_drive_k%0d: got %h required fb", k, c_an[k]); end
        end
        n_cmp++; if (c_an[12] !== 8'hFF) begin n_err++; $display("FAIL next_slot_dark: got %h required ff", c_an[12]); end
        n_cmp++; if (c_dp[2] !== 1'b1) begin n_err++; $display("FAIL no_dp: got %b required 1", c_dp[2]); end
    endtask

    task automatic test_zero_dp;
        set_bt(32'h0000_0000);
        capture_frame();
        n_cmp++; if (c_seg[2] !== 7'h40) begin n_err++; $display("FAIL zero_digit0: got %h required 40", c_seg[2]); end
        for (int d = 1; d <= 7; d++) begin
            n_cmp++;
            if (c_seg[4*d+2] !== 7'h7F) begin n_err++; $display("FAIL zero_lz_digit%0d: got %h required 7f", d, c_seg[4*d+2]); end
        end
        n_cmp++; if (c_dp[10] !== 1'b1) begin n_err++; $display("FAIL zero_no_dp: got %b required 1", c_dp[10]); end
        for (int d = 0; d <= 2; d++) begin
            n_cmp++;
            if (c2_seg[4*d+2] !== 7'h40) begin n_err++; $display("FAIL dp2_digit%0d: got %h required 40", d, c2_seg[4*d+2]); end
        end
        n_cmp++; if (c2_dp[10] !== 1'b0) begin n_err++; $display("FAIL dp2_point: got %b required 0", c2_dp[10]); end
        n_cmp++; if (c2_dp[6] !== 1'b1) begin n_err++; $display("FAIL dp2_digit1_dp: got %b required 1", c2_dp[6]); end
        n_cmp++; if (c2_seg[14] !== 7'h7F) begin n_err++; $display("FAIL dp2_digit3_lz: got %h required 7f", c2_seg[14]); end
    endtask

    task automatic test_dash;
        set_bt(32'hF000_000C);
        capture_frame();
        n_cmp++; if (c_seg[2] !== 7'h3F) begin n_err++; $display("FAIL dash_digit0: got %h required 3f", c_seg[2]); end
        n_cmp++; if (c_seg[30] !== 7'h3F) begin n_err++; $display("FAIL dash_digit7: got %h required 3f", c_seg[30]); end
        n_cmp++; if (c_seg[22] !== 7'h40) begin n_err++; $display("FAIL inner_zero: got %h required 40", c_seg[22]); end
    endtask

    task automatic test_no_tearing;
        bit ok;
        int n;
        set_bt(32'h0000_1000);
        wait_frame(ok);
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            if (k == 14) begin
                n_cmp++; if (seg !== 7'h79) begin n_err++; $display("FAIL tear_old: got %h required 79", seg); end
            end
            if (k == 10) bt3 = 4'd7;
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin n = i; break; end
        end
        n_cmp++; if (n != 1) begin n_err++; $display("FAIL tear_next_frame: got %0d required 1", n); end
        repeat (14) @(negedge clk);
        n_cmp++; if (an !== 8'hF7) begin n_err++; $display("FAIL tear_an: got %h required f7", an); end
        n_cmp++; if (seg !== 7'h78) begin n_err++; $display("FAIL tear_new: got %h required 78", seg); end
    endtask

    task automatic test_async_reset;
        bit ok;
        int n;
        set_bt(32'h0000_1000);
        wait_frame(ok);
        repeat (13) @(negedge clk);
        n_cmp++; if (an !== 8'hF7) begin n_err++; $display("FAIL pre_rst_an: got %h required f7", an); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL async_an: got %h required ff", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL async_seg: got %h required 7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL async_dp: got %b required 1", dp); end
        n_cmp++; if (frame !== 1'b0) begin n_err++; $display("FAIL async_frame: got %b required 0", frame); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (frame !== 1'b1) begin n_err++; $display("FAIL rel_frame: got %b required 1", frame); end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin n = i; break; end
        end
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL rel_period: got %0d required 32", n); end
    endtask

    task automatic test_random;
        bit ok;
        logic [7:0] exp_an;
        logic       exp_frame;
        wait_frame(ok);
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) @(negedge clk);
            exp_an    = (k % 4 == 0) ? 8'hFF : ~(8'd1 << ((k / 4) % 8));
            exp_frame = (k % 32 == 0);
            n_cmp++; if (an !== exp_an) begin n_err++; $display("FAIL rand_an k=%0d: got %h required %h", k, an, exp_an); end
            n_cmp++; if ($countones(~an) > 1) begin n_err++; $display("FAIL rand_onehot k=%0d: got %h required <=1 low", k, an); end
            n_cmp++; if (frame !== exp_frame) begin n_err++; $display("FAIL rand_frame k=%0d: got %b required %b", k, frame, exp_frame); end
            set_bt($urandom());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_digits();
        test_zero_dp();
        test_dash();
        test_no_tearing();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
